// File: rtl/elc3_sysinfo_pkg.sv
// Shared constants for the system-information slave: register map,
// CONTROL bit positions and the capability word builder.
package elc3_sysinfo_pkg;

    localparam logic [2:0] ADDR_ID        = 3'd0;
    localparam logic [2:0] ADDR_TS        = 3'd1;
    localparam logic [2:0] ADDR_CAPS      = 3'd2;
    localparam logic [2:0] ADDR_UPTIME_LO = 3'd3;
    localparam logic [2:0] ADDR_UPTIME_HI = 3'd4;
    localparam logic [2:0] ADDR_CONTROL   = 3'd5;
    localparam logic [2:0] ADDR_SCRATCH0  = 3'd6;
    localparam logic [2:0] ADDR_SCRATCH1  = 3'd7;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_CLR    = 1;
    localparam int NUM_SCRATCH = 2;

    function automatic logic [31:0] caps_word(input logic [15:0] version,
                                              input logic [7:0]  latency);
        return {version, latency, 8'(NUM_SCRATCH)};
    endfunction

endpackage

// File: rtl/elc3_sysinfo_rd_pipe.sv
// Valid+data delay line: each stage only captures data when its input is
// valid, so the output data holds the last delivered word between pulses.
module elc3_sysinfo_rd_pipe #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             vchain_s [DEPTH+1];
    logic [WIDTH-1:0] dchain_s [DEPTH+1];

    assign vchain_s[0] = in_valid;
    assign dchain_s[0] = in_data;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             valid_q, valid_d;
        logic [WIDTH-1:0] data_q, data_d;

        // Next-state for one stage: valid always shifts, data only on valid.
        always_comb begin
            valid_d = vchain_s[g];
            if (vchain_s[g]) begin
                data_d = dchain_s[g];
            end else begin
                data_d = data_q;
            end
        end

        // Stage registers, flushed by reset so in-flight reads are lost.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= {WIDTH{1'b0}};
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign vchain_s[g+1] = valid_q;
        assign dchain_s[g+1] = data_q;
    end

    assign out_valid = vchain_s[DEPTH];
    assign out_data  = dchain_s[DEPTH];

endmodule

// File: rtl/elc3_soc_sysinfo.sv
// System-information Avalon-MM slave: identity, timestamp, capabilities,
// 64-bit uptime counter with LO/HI snapshot, control and scratch registers.
module elc3_soc_sysinfo
    import elc3_sysinfo_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP    = 32'd0,
    parameter logic [15:0] VERSION      = 16'h0002,
    parameter int          READ_LATENCY = 1,
    parameter logic        CNT_RESET_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("elc3_soc_sysinfo: READ_LATENCY must be in 1..4");
    end

    localparam logic [31:0] CAPS_VALUE = caps_word(VERSION, 8'(READ_LATENCY));

    logic [63:0] uptime_q, uptime_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] scratch0_q, scratch0_d;
    logic [31:0] scratch1_q, scratch1_d;
    logic        en_q, en_d;

    logic        rd_accept_s;
    logic        ctrl_wr_s;
    logic [31:0] rd_data_s;

    // A read colliding with a write is dropped; the write still lands.
    assign rd_accept_s = read & ~write;
    assign ctrl_wr_s   = write & (address == ADDR_CONTROL);

    // Register and counter next-state; clear takes priority over increment.
    always_comb begin
        if (ctrl_wr_s) begin
            en_d = writedata[CTRL_EN];
        end else begin
            en_d = en_q;
        end

        if (ctrl_wr_s && writedata[CTRL_CLR]) begin
            uptime_d = 64'd0;
        end else if (en_q) begin
            uptime_d = uptime_q + 64'd1;
        end else begin
            uptime_d = uptime_q;
        end

        if (rd_accept_s && (address == ADDR_UPTIME_LO)) begin
            shadow_d = uptime_q[63:32];
        end else begin
            shadow_d = shadow_q;
        end

        if (write && (address == ADDR_SCRATCH0)) begin
            scratch0_d = writedata;
        end else begin
            scratch0_d = scratch0_q;
        end

        if (write && (address == ADDR_SCRATCH1)) begin
            scratch1_d = writedata;
        end else begin
            scratch1_d = scratch1_q;
        end
    end

    // Read mux, sampled on current (pre-edge) register values.
    always_comb begin
        case (address)
            ADDR_ID:        rd_data_s = SYSTEM_ID;
            ADDR_TS:        rd_data_s = TIMESTAMP;
            ADDR_CAPS:      rd_data_s = CAPS_VALUE;
            ADDR_UPTIME_LO: rd_data_s = uptime_q[31:0];
            ADDR_UPTIME_HI: rd_data_s = shadow_q;
            ADDR_CONTROL:   rd_data_s = {31'd0, en_q};
            ADDR_SCRATCH0:  rd_data_s = scratch0_q;
            ADDR_SCRATCH1:  rd_data_s = scratch1_q;
            default:        rd_data_s = 32'd0;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            uptime_q   <= 64'd0;
            shadow_q   <= 32'd0;
            scratch0_q <= 32'd0;
            scratch1_q <= 32'd0;
            en_q       <= CNT_RESET_EN;
        end else begin
            uptime_q   <= uptime_d;
            shadow_q   <= shadow_d;
            scratch0_q <= scratch0_d;
            scratch1_q <= scratch1_d;
            en_q       <= en_d;
        end
    end

    elc3_sysinfo_rd_pipe #(
        .DEPTH (READ_LATENCY),
        .WIDTH (32)
    ) u_rd_pipe (
        .clk       (clock),
        .rst_n     (reset_n),
        .in_valid  (rd_accept_s),
        .in_data   (rd_data_s),
        .out_valid (readdatavalid),
        .out_data  (readdata)
    );

endmodule

// File: tb/tb_elc3_soc_sysinfo.sv
// Scoreboard bench: three instances (latency 1, 3, 4) share the write bus;
// reads push expected words and due cycles, negedge monitors pop and compare.
module tb_elc3_soc_sysinfo;
    import elc3_sysinfo_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        reset_n4;
    logic [2:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read1, read3, read4;
    logic [31:0] rd1, rd3, rd4;
    logic        rdv1, rdv3, rdv4;

    typedef struct {
        logic [31:0] data;
        logic [31:0] mask;
        int          due;
        int          tag;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    exp_t q4[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int tag_cnt = 0;
    int rdv1_cnt = 0;
    int rdv4_cnt = 0;
    int snap;

    elc3_soc_sysinfo #(
        .SYSTEM_ID(32'h1234_5678), .TIMESTAMP(32'h65A0_0000),
        .VERSION(16'h0002), .READ_LATENCY(1), .CNT_RESET_EN(1'b1)
    ) dut1 (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read1),
        .write(write), .writedata(writedata), .readdata(rd1), .readdatavalid(rdv1)
    );

    elc3_soc_sysinfo #(
        .SYSTEM_ID(32'hA5A5_0003), .TIMESTAMP(32'h6000_0000),
        .VERSION(16'h0002), .READ_LATENCY(3), .CNT_RESET_EN(1'b0)
    ) dut3 (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read3),
        .write(write), .writedata(writedata), .readdata(rd3), .readdatavalid(rdv3)
    );

    elc3_soc_sysinfo #(
        .SYSTEM_ID(32'hC0DE_0004), .TIMESTAMP(32'h0000_0004),
        .VERSION(16'h0002), .READ_LATENCY(4), .CNT_RESET_EN(1'b1)
    ) dut4 (
        .clock(clock), .reset_n(reset_n4), .address(address), .read(read4),
        .write(write), .writedata(writedata), .readdata(rd4), .readdatavalid(rdv4)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic mon(input int inst, input logic [31:0] act);
        exp_t e;
        bit   have;
        have = 1'b0;
        case (inst)
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            3: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
            4: if (q4.size() > 0) begin e = q4.pop_front(); have = 1'b1; end
            default: ;
        endcase
        if (!have) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_valid dut%0d: readdata=%h at cycle %0d, required no pulse", inst, act, cyc);
        end else begin
            check($sformatf("rd_data dut%0d #%0d", inst, e.tag), 64'(act & e.mask), 64'(e.data & e.mask));
            check($sformatf("rd_latency dut%0d #%0d", inst, e.tag), 64'(cyc), 64'(e.due));
        end
    endtask

    always @(negedge clock) begin
        if (rdv1) begin rdv1_cnt++; mon(1, rd1); end
        if (rdv3) mon(3, rd3);
        if (rdv4) begin rdv4_cnt++; mon(4, rd4); end
    end

    function automatic int lat_of(input int inst);
        return (inst == 1) ? 1 : ((inst == 3) ? 3 : 4);
    endfunction

    // One bus cycle of read; expected word is queued only when a response is due.
    task automatic do_read(input int inst, input logic [2:0] addr, input logic [31:0] exp,
                           input logic [31:0] mask, input bit expect_resp);
        exp_t e;
        e.data = exp;
        e.mask = mask;
        e.due  = cyc + lat_of(inst);
        e.tag  = tag_cnt;
        tag_cnt++;
        address = addr;
        case (inst)
            1: begin read1 = 1'b1; if (expect_resp) q1.push_back(e); end
            3: begin read3 = 1'b1; if (expect_resp) q3.push_back(e); end
            4: begin read4 = 1'b1; if (expect_resp) q4.push_back(e); end
            default: ;
        endcase
        @(posedge clock); #1;
        read1 = 1'b0; read3 = 1'b0; read4 = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] addr, input logic [31:0] data);
        address = addr; writedata = data; write = 1'b1;
        @(posedge clock); #1;
        write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; reset_n4 = 1'b0;
        address = 3'd0; write = 1'b0; writedata = 32'd0;
        read1 = 1'b0; read3 = 1'b0; read4 = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_valid", {61'd0, rdv1, rdv3, rdv4}, 64'd0);
        check("reset_rdata1", 64'(rd1), 64'd0);
        check("reset_rdata3", 64'(rd3), 64'd0);
        reset_n = 1'b1; reset_n4 = 1'b1;
        idle(1);

        // Identity and capability words, latency 1.
        do_read(1, ADDR_ID,   32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
        do_read(1, ADDR_CAPS, 32'h0002_0102, 32'hFFFF_FFFF, 1'b1);
        do_read(1, ADDR_TS,   32'h65A0_0000, 32'hFFFF_FFFF, 1'b1);
        idle(2);

        // Back-to-back reads through a three-stage pipe.
        do_read(3, ADDR_ID,       32'hA5A5_0003, 32'hFFFF_FFFF, 1'b1);
        do_read(3, ADDR_TS,       32'h6000_0000, 32'hFFFF_FFFF, 1'b1);
        do_read(3, ADDR_SCRATCH0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
        do_read(3, ADDR_CONTROL,  32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
        do_read(3, ADDR_CAPS,     32'h0002_0302, 32'hFFFF_FFFF, 1'b1);
        idle(5);

        // Stop-and-clear, scratch write, frozen counter.
        do_write(ADDR_CONTROL, 32'h0000_0002);
        do_write(ADDR_SCRATCH1, 32'hDEAD_BEEF);
        do_write(ADDR_ID, 32'hFFFF_FFFF);
        do_read(1, ADDR_SCRATCH1,  32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1);
        do_read(1, ADDR_ID,        32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
        do_read(1, ADDR_UPTIME_LO, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
        idle(10);
        do_read(1, ADDR_UPTIME_LO, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
        do_read(1, ADDR_UPTIME_HI, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
        do_read(1, ADDR_CONTROL,   32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
        idle(2);

        // Enable with clear: counter restarts from zero.
        do_write(ADDR_CONTROL, 32'h0000_0003);
        do_read(1, ADDR_CONTROL,   32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
        do_read(1, ADDR_UPTIME_LO, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
        do_read(1, ADDR_UPTIME_HI, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
        idle(2);

        // Low-word boundary: snapshot taken before the carry into the high word.
        force dut1.uptime_q = 64'h0000_0000_FFFF_FFFF;
        do_read(1, ADDR_UPTIME_LO, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        release dut1.uptime_q;
        do_read(1, ADDR_UPTIME_HI, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
        idle(2);
        do_read(1, ADDR_UPTIME_LO, 32'h0000_0000, 32'h0000_0000, 1'b1);
        do_read(1, ADDR_UPTIME_HI, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
        idle(2);

        // Reset while a latency-4 read is in flight.
        snap = rdv4_cnt;
        do_read(4, ADDR_ID, 32'hC0DE_0004, 32'hFFFF_FFFF, 1'b0);
        idle(1);
        reset_n4 = 1'b0;
        idle(3);
        check("rst_rdata4", 64'(rd4), 64'd0);
        reset_n4 = 1'b1;
        idle(6);
        check("rst_flush_pulses", 64'(rdv4_cnt), 64'(snap));
        do_read(4, ADDR_CAPS,    32'h0002_0402, 32'hFFFF_FFFF, 1'b1);
        do_read(4, ADDR_CONTROL, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
        idle(6);

        // Colliding read and write: write lands, read is dropped.
        snap = rdv1_cnt;
        address = ADDR_SCRATCH0; writedata = 32'hCAFE_F00D; write = 1'b1; read1 = 1'b1;
        @(posedge clock); #1;
        write = 1'b0; read1 = 1'b0;
        idle(3);
        check("rw_collision_pulses", 64'(rdv1_cnt), 64'(snap));
        do_read(1, ADDR_SCRATCH0, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b1);
        idle(8);

        check("pending_dut1", 64'(q1.size()), 64'd0);
        check("pending_dut3", 64'(q3.size()), 64'd0);
        check("pending_dut4", 64'(q4.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/elc3_soc_sysinfo.md
Name: elc3_soc_sysinfo

Overview:
- Parametrised system-information Avalon-MM slave. Successor to the fixed two-word system ID slave.
- Provides an identity word, build timestamp and capability words.
- Adds a 64-bit free-running uptime counter with atomic snapshot, a control register, two scratch registers and a configurable read latency with readdatavalid.
- Sits on the SoC control interconnect. Software reads it at boot for identification and uses it at run time for timing.

Parameters:
- SYSTEM_ID, 32'h0000_0000, value returned at word 0.
- TIMESTAMP, 32'd0, build time (Unix seconds) returned at word 1.
- VERSION, 16'h0002, block version reported in CAPS[31:16].
- READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal range 1..4, elaboration error outside it.
- CNT_RESET_EN, 1, reset value of CONTROL.en.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  3  word address
- read  in  1  read strobe, accepted every cycle (no waitrequest)
- write  in  1  write strobe, accepted every cycle
- writedata  in  32  write data, full-word writes only
- readdata  out  32  read data, valid when readdatavalid=1
- readdatavalid  out  1  one-cycle pulse per accepted read

Behaviour:
- Reset: clock and reset_n as decided (one clock, asynchronous active-low reset). All state is cleared asynchronously:
  - readdata=0, readdatavalid=0
  - uptime=0, shadow=0, scratch0/1=0
  - CONTROL.en=CNT_RESET_EN
  - read pipeline empty
- Register map (word addresses):
  - 0 ID: RO, SYSTEM_ID.
  - 1 TS: RO, TIMESTAMP.
  - 2 CAPS: RO, {VERSION, 8'(READ_LATENCY), 8'h02}, where the low byte is the scratch count.
  - 3 UPTIME_LO: RO. Returns uptime[31:0] as sampled in the accept cycle. In the same cycle shadow <= uptime[63:32].
  - 4 UPTIME_HI: RO. Returns shadow.
  - 5 CONTROL: RW. bit0 en; bit1 clr is write-1 pulse and reads 0; bits[31:2] read 0.
  - 6 SCRATCH0: RW.
  - 7 SCRATCH1: RW.
- Writes to RO addresses are ignored.
- Uptime counter:
  - 64-bit; increments by 1 each cycle while en=1.
  - Wraps from 2^64-1 to 0 with no flag.
  - A write to CONTROL with bit1=1 zeroes the counter on the next edge. Clear beats increment.
  - New en takes effect from the cycle after the write.
  - Read sampling uses the pre-edge (current-cycle) counter value.
- Read pipeline:
  - Data is selected combinationally in the accept cycle, then delayed by READ_LATENCY register stages.
  - readdatavalid is asserted exactly READ_LATENCY cycles after the read.
  - Back-to-back reads are fully pipelined, so N consecutive reads give N consecutive valid pulses in order.
  - readdata holds its last value when readdatavalid=0.
- Simultaneous read and write in one cycle (illegal on the bus): the write is performed; the read is dropped and produces no readdatavalid.
- Read-after-write to the same register in consecutive cycles returns the new value.
- Reset mid-operation: the pipeline is flushed, so in-flight reads never produce a readdatavalid.
- No arithmetic beyond the counter increment. All register widths are exactly 32 bits.

Decomposition:
- Package elc3_sysinfo_pkg holds:
  - address constants ADDR_ID..ADDR_SCRATCH1
  - CONTROL bit indices CTRL_EN=0, CTRL_CLR=1
  - NUM_SCRATCH=2
- Sub-module elc3_sysinfo_rd_pipe: parametrised (DEPTH, WIDTH) valid+data shift register with asynchronous reset, implementing the READ_LATENCY delay.
- The top level contains the decode, the registers and the counter.

Test Plan:
- Reset, then READ_LATENCY=1 and SYSTEM_ID=32'h12345678: read addr0 -> readdatavalid exactly 1 cycle later with readdata=32'h12345678. Read addr2 -> 32'h00020102.
- READ_LATENCY=3: reads to addr0, 1, 6 on three consecutive cycles -> three consecutive valid pulses starting 3 cycles after the first read, data in order.
- Write CONTROL=0 (stop), write 32'hDEADBEEF to SCRATCH1 -> read returns 32'hDEADBEEF and the uptime value is frozen across 10 cycles. Read CONTROL -> 0.
- Force uptime to 64'h0000_0000_FFFF_FFFE with en=1, then read LO on the cycle it reaches 64'h0000_0000_FFFF_FFFF -> LO=32'hFFFFFFFF. A subsequent HI read -> 0, even though the counter has carried to 1<<32.
- With en=1, write CONTROL=32'h3 -> counter 0 on the next edge, then increments. An immediate CONTROL read -> 32'h1.
- Issue a read with READ_LATENCY=4, assert reset_n=0 two cycles later -> no readdatavalid at any time. Simultaneous read+write to SCRATCH0 -> value written, no valid pulse.
